sha256_core_arbiter: RTL and testbench

- Shares one SHA_256_Top instance between NUM_REQ requesters, for example the Merkle root engine and the nonce/header miner.
- Accepts one 512-bit block plus a 256-bit chaining value per request, issues one start pulse to the core, and waits for the done pulse.
- Returns the digest to the granted requester only.
- Uses round-robin arbitration, holds core inputs stable for the whole hash, and applies a watchdog timeout.

---
 rtl/sha256_arb_pkg.sv | 18 +
 rtl/sha256_core_arbiter_picker.sv | 31 +++
 rtl/sha256_core_arbiter.sv | 119 +++++++++++
 tb/tb_sha256_core_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_arb_pkg.sv
// Shared widths, FSM encoding and SHA-256 IV for the core arbiter
// and the requesters that feed it.
package sha256_arb_pkg;

    localparam int MSG_W  = 512;
    localparam int HASH_W = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [HASH_W-1:0] SHA256_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

endpackage

// File: rtl/sha256_core_arbiter_picker.sv
// Round-robin priority picker: first set request at or above rr_ptr,
// wrapping around to bit 0.
module rr_priority_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    int cand;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(rr_ptr) + i) % N;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sha256_core_arbiter.sv
// Shares one SHA-256 core between NUM_REQ requesters with round-robin
// arbitration, stable core inputs during a hash and a watchdog timeout.
module sha256_core_arbiter
    import sha256_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*MSG_W-1:0]   req_message,
    input  logic [NUM_REQ*HASH_W-1:0]  req_init,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [HASH_W-1:0]          resp_digest,
    output logic                       resp_error,
    output logic                       busy,
    output logic                       core_start,
    output logic [MSG_W-1:0]           core_message,
    output logic [HASH_W-1:0]          core_init,
    input  logic [HASH_W-1:0]          core_digest,
    input  logic                       core_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant;
    logic [NUM_REQ-1:0]   grant_hot;
    logic [CNT_W-1:0]     watchdog;
    logic [NUM_REQ-1:0]   pick_hot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 timeout;
    logic [IDX_W-1:0]     next_ptr;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_hot),
        .index  (pick_idx),
        .any    (pick_any)
    );

    assign timeout  = (watchdog == CNT_W'(TIMEOUT_CYCLES - 1));
    assign next_ptr = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            grant_hot    <= '0;
            watchdog     <= '0;
            req_ready    <= '0;
            resp_valid   <= '0;
            resp_digest  <= '0;
            resp_error   <= 1'b0;
            busy         <= 1'b0;
            core_start   <= 1'b0;
            core_message <= '0;
            core_init    <= '0;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            core_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        core_message <= req_message[pick_idx*MSG_W +: MSG_W];
                        core_init    <= req_init[pick_idx*HASH_W +: HASH_W];
                        grant        <= pick_idx;
                        grant_hot    <= pick_hot;
                        req_ready    <= pick_hot;
                        core_start   <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // core_done takes priority over an expiring watchdog
                    if (core_done) begin
                        resp_digest <= core_digest;
                        resp_error  <= 1'b0;
                        resp_valid  <= grant_hot;
                        state       <= RESP;
                    end else if (timeout) begin
                        resp_digest  <= '0;
                        resp_error   <= 1'b1;
                        resp_valid   <= grant_hot;
                        core_message <= '0;
                        core_init    <= '0;
                        state        <= RESP;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr     <= next_ptr;
                    resp_error <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Directed bench for sha256_core_arbiter with a behavioural core stub
// and a table of transactions plus reset and stale-done sequences.
module tb_sha256_core_arbiter;

    localparam int N  = 2;
    localparam int T  = 256;
    localparam int CW = 9;

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*512-1:0] req_message = '0;
    logic [N*256-1:0] req_init = '0;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     resp_valid;
    logic [255:0]     resp_digest;
    logic             resp_error;
    logic             busy;
    logic             core_start;
    logic [511:0]     core_message;
    logic [255:0]     core_init;
    logic [255:0]     core_digest = '0;
    logic             core_done = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [511:0] abc_blk;

    sha256_core_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_message  (req_message),
        .req_init     (req_init),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_digest  (resp_digest),
        .resp_error   (resp_error),
        .busy         (busy),
        .core_start   (core_start),
        .core_message (core_message),
        .core_init    (core_init),
        .core_digest  (core_digest),
        .core_done    (core_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        int         idx;
        bit         keep;
        int         lat;
        bit         err;
        bit         late;
        bit         do_rst;
    } vec_t;

    vec_t tbl[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    function automatic logic [255:0] model(input logic [511:0] m,
                                           input logic [255:0] h);
        if (m == abc_blk && h == IV)
            return ABC_DIG;
        return m[511:256] ^ m[255:0] ^ {h[127:0], h[255:128]};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_digest"}, resp_digest, 0);
        chk({tag, "_resp_error"}, resp_error, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_message"}, core_message, 0);
        chk({tag, "_core_init"}, core_init, 0);
    endtask

    task automatic load(input int e);
        logic [511:0] m0;
        m0 = (e == 0) ? abc_blk : {16{32'h1000_0000 + 32'(e)}};
        req_message = {{16{32'h2000_0000 + 32'(e)}}, m0};
        req_init    = {~IV, IV};
    endtask

    // Caller has set req_valid/req_message/req_init in an IDLE cycle.
    task automatic transact(input int idx, input bit keep, input int lat,
                            input bit err);
        logic [511:0] msg;
        logic [255:0] ini;
        logic [255:0] dig;
        logic [1:0]   hot;
        int           w;
        msg = req_message[idx*512 +: 512];
        ini = req_init[idx*256 +: 256];
        dig = err ? 256'h0 : model(msg, ini);
        hot = 2'b01 << idx;
        step();
        chk("issue_req_ready", req_ready, hot);
        chk("issue_core_start", core_start, 1);
        chk("issue_busy", busy, 1);
        chk("issue_core_message", core_message, msg);
        chk("issue_core_init", core_init, ini);
        if (!keep)
            req_valid[idx] = 1'b0;
        step();
        chk("wait_core_start", core_start, 0);
        chk("wait_req_ready", req_ready, 0);
        w = 1;
        forever begin
            if (w == lat) begin
                core_done   = 1'b1;
                core_digest = model(core_message, core_init);
            end
            step();
            core_done = 1'b0;
            if (resp_valid != 0)
                break;
            if (w >= T + 4) begin
                chk("resp_timeout_bound", 0, 1);
                break;
            end
            w++;
        end
        chk("wait_cycles", w, (lat != 0) ? lat : T);
        chk("resp_valid", resp_valid, hot);
        chk("resp_digest", resp_digest, dig);
        chk("resp_error", resp_error, err);
        chk("resp_core_message", core_message, err ? 512'h0 : msg);
        step();
        chk("idle_resp_valid", resp_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        abc_blk = {32'h61626380, 416'h0, 64'h18};

        tbl[0]  = '{2'b01, 0, 0, 3, 0, 0, 1};
        tbl[1]  = '{2'b11, 0, 0, 5, 0, 0, 1};
        tbl[2]  = '{2'b11, 1, 0, 2, 0, 0, 0};
        tbl[3]  = '{2'b11, 0, 1, 1, 0, 0, 0};
        tbl[4]  = '{2'b11, 1, 1, 4, 0, 0, 0};
        tbl[5]  = '{2'b11, 0, 1, 2, 0, 0, 0};
        tbl[6]  = '{2'b11, 1, 1, 7, 0, 0, 0};
        tbl[7]  = '{2'b11, 0, 1, 3, 0, 0, 0};
        tbl[8]  = '{2'b11, 1, 1, 1, 0, 0, 0};
        tbl[9]  = '{2'b10, 1, 0, 2, 0, 0, 0};
        tbl[10] = '{2'b01, 0, 0, 2, 0, 0, 0};
        tbl[11] = '{2'b01, 0, 0, 6, 0, 0, 0};
        tbl[12] = '{2'b10, 1, 0, 0, 1, 1, 0};
        tbl[13] = '{2'b01, 0, 0, T, 0, 0, 0};

        for (int e = 0; e < 14; e++) begin
            if (tbl[e].do_rst) begin
                req_valid = '0;
                rst = 1'b1;
                step();
                step();
                chk_all_zero("reset");
                rst = 1'b0;
            end
            load(e);
            req_valid = tbl[e].req;
            transact(tbl[e].idx, tbl[e].keep, tbl[e].lat, tbl[e].err);
            if (tbl[e].late) begin
                for (int k = 0; k < 3; k++) begin
                    core_done = (k == 0);
                    step();
                    core_done = 1'b0;
                    chk("late_done_resp_valid", resp_valid, 0);
                    chk("late_done_busy", busy, 0);
                end
            end
        end

        // Reset in the middle of WAIT
        load(20);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        step();
        step();
        rst = 1'b0;
        core_done   = 1'b1;
        core_digest = ~256'h0;
        step();
        core_done = 1'b0;
        chk("stale_done_resp_valid", resp_valid, 0);
        chk("stale_done_busy", busy, 0);
        step();
        chk("stale_done_resp_valid2", resp_valid, 0);

        // rr_ptr must be back at 0 after reset
        load(21);
        req_valid = 2'b11;
        transact(0, 0, 4, 0);
        req_valid = '0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
